// File: rtl/clkdiv_ctrl_if.sv
// Control and status bundle of the clock divider: run/stop/step requests,
// divisor reconfiguration handshake and the divided-clock status outputs.
interface clkdiv_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             stop;
  logic             step;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [15:0]      periods;

  modport master (
    output start, stop, step, cfg_valid, cfg_div,
    input  cfg_ready, clk_out, tick, busy, periods
  );

  modport slave (
    input  start, stop, step, cfg_valid, cfg_div,
    output cfg_ready, clk_out, tick, busy, periods
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with free-run, glitch-free stop and single-period
// step modes; divisor changes while running are deferred to the next toggle.
module clkdiv_ctrl #(
  parameter int unsigned DEFAULT_DIV = 2500000,
  parameter int          CNT_W       = 32
) (
  input  logic         clk_in,
  input  logic         rst_n,
  clkdiv_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;
  localparam logic [1:0] S_STEP     = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] pend_reg, pend_next;
  logic             pend_valid_reg, pend_valid_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic [15:0]      periods_reg, periods_next;

  logic             terminal;
  logic             hs;
  logic             toggle;
  logic             go_idle;
  logic [CNT_W-1:0] cfg_val;

  // ">=" rather than "==" so a counter left beyond a shrunken divisor still wraps
  assign terminal = (cnt_reg >= (div_reg - CNT_W'(1)));
  assign hs       = bus.cfg_valid && !pend_valid_reg;
  assign cfg_val  = (bus.cfg_div == '0) ? CNT_W'(1) : bus.cfg_div;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    div_next        = div_reg;
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    clk_out_next    = clk_out_reg;
    tick_next       = 1'b0;
    periods_next    = periods_reg;
    toggle          = 1'b0;
    go_idle         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        if (hs) div_next = cfg_val;
        if (!bus.stop) begin
          if (bus.step)       state_next = S_STEP;
          else if (bus.start) state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop && !clk_out_reg) begin
          go_idle = 1'b1;
        end else begin
          toggle = terminal;
          // a stop landing on the falling edge itself can finish immediately
          if (bus.stop) begin
            if (terminal) go_idle = 1'b1;
            else          state_next = S_STOPPING;
          end
        end
      end
      S_STOPPING: begin
        if (terminal) begin
          toggle  = 1'b1;
          go_idle = 1'b1;
        end
      end
      S_STEP: begin
        // the end of the high phase closes the step without a tick
        if (terminal) begin
          if (clk_out_reg) go_idle = 1'b1;
          else             toggle  = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (state_reg != S_IDLE) begin
      cnt_next = terminal ? '0 : cnt_reg + CNT_W'(1);
    end

    if (toggle) begin
      clk_out_next = ~clk_out_reg;
      tick_next    = 1'b1;
      if (!clk_out_reg) periods_next = periods_reg + 16'd1;
    end

    if (go_idle) begin
      state_next   = S_IDLE;
      cnt_next     = '0;
      clk_out_next = 1'b0;
    end

    if ((toggle || go_idle) && pend_valid_reg) begin
      div_next        = pend_reg;
      pend_valid_next = 1'b0;
    end

    // pending is only parked when the block keeps running past this edge
    if (state_reg != S_IDLE && hs) begin
      if (go_idle) begin
        div_next = cfg_val;
      end else begin
        pend_next       = cfg_val;
        pend_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      div_reg        <= CNT_W'(DEFAULT_DIV);
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      clk_out_reg    <= 1'b0;
      tick_reg       <= 1'b0;
      periods_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      div_reg        <= div_next;
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      clk_out_reg    <= clk_out_next;
      tick_reg       <= tick_next;
      periods_reg    <= periods_next;
    end
  end

  assign bus.cfg_ready = ~pend_valid_reg;
  assign bus.clk_out   = clk_out_reg;
  assign bus.tick      = tick_reg;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.periods   = periods_reg;
endmodule
